b1_boc_gen: RTL
===============

B1_BOC_GEN -- requirements
Module: b1_boc_gen

Interface
REQ-001 Parameter G2_TAP_A, default 1, meaning first G2 phase-select stage (1..11) for PRN selection.
REQ-002 Parameter G2_TAP_B, default 3, meaning second G2 phase-select stage (1..11).
REQ-003 Parameter NAV_EPOCHS, default 20, meaning code periods per navigation bit.
REQ-004 Port rx_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port rx_rst  input  1  reset, asynchronous, active-low.
REQ-006 Port tx_en  input  1  generator enable; low freezes all state.
REQ-007 Port tx_sync  input  1  one-cycle synchronous restart of code, subcarrier and epoch phase.
REQ-008 Port tx_car_fcw  input  32  carrier NCO frequency control word.
REQ-009 Port tx_prn_fcw  input  32  code NCO FCW; one accumulator carry = one half-chip.
REQ-010 Port tx_nav_bit  input  1  next navigation bit, sampled on tx_nav_req.
REQ-011 Port tx_src  output  8  signed two's-complement IF sample.
REQ-012 Port tx_src_valid  output  1  tx_src updated this cycle.
REQ-013 Port tx_prn_sop  output  1  one-cycle pulse at code-period start.
REQ-014 Port tx_nav_req  output  1  one-cycle pulse at nav-bit boundary.
REQ-015 Port tx_chip  output  1  current Gold-code chip (unmodulated).

Function
REQ-016 G1 and G2 SHALL be 11-stage LFSRs, stages 1..11, shifting stage n to n+1, feedback into stage 1, both initialised to 01010101010 (stage 1 first).
REQ-017 G1 feedback SHALL be XOR of stages 1,7,8,9,10,11; G2 feedback XOR of stages 1,2,3,4,5,8,9,11.
REQ-018 tx_chip SHALL equal G1[11] XOR G2[G2_TAP_A] XOR G2[G2_TAP_B].
REQ-019 On each cycle with tx_en=1: car_acc += tx_car_fcw, code_acc += tx_prn_fcw, both 32-bit modulo 2^32.
REQ-020 A code_acc carry-out SHALL be a half-chip tick; each tick toggles subcarrier bit sub.
REQ-021 On a tick with sub=1 (second half-chip): LFSRs shift once, chip_cnt increments.
REQ-022 When chip_cnt would reach 2046: chip_cnt:=0, LFSRs reload initial value, tx_prn_sop pulses next cycle, epoch_cnt increments.
REQ-023 When epoch_cnt would reach NAV_EPOCHS: epoch_cnt:=0, nav:=tx_nav_bit latched same edge, tx_nav_req pulses coincident with tx_prn_sop.
REQ-024 Sign d SHALL be tx_chip XOR sub XOR nav.
REQ-025 Carrier LUT on car_acc[31:29]: 0:+64,1:+45,2:0,3:-45,4:-64,5:-45,6:0,7:+45.
REQ-026 tx_src SHALL be registered: LUT value if d=0, its negation if d=1; latency one cycle from accumulator/LFSR state.
REQ-027 tx_src_valid SHALL be tx_en delayed one cycle.
REQ-028 tx_en=0: accumulators, LFSRs, counters, sub, nav held; tx_src holds last value; pulses 0.
REQ-029 tx_sync=1 (priority over tick, independent of tx_en): code_acc:=0, sub:=0, chip_cnt:=0, epoch_cnt:=0, LFSRs reload; car_acc and nav unchanged; tx_prn_sop pulses next cycle.
REQ-030 Simultaneous period wrap and tx_sync: single tx_prn_sop pulse, sync state wins.
REQ-031 Arbitrary tx_prn_fcw change takes effect on the next accumulation; no phase jump.

Reset
REQ-032 rx_rst=0 SHALL immediately clear car_acc, code_acc, sub, chip_cnt, epoch_cnt, nav, tx_src, tx_src_valid, tx_prn_sop, tx_nav_req to 0 and load LFSRs with 01010101010.
REQ-033 Reset asserted mid-period SHALL abandon the period; first enabled cycle after release restarts from chip 0, sub 0, carrier phase 0.

Verification
REQ-034 Reset: rx_rst low mid-run -> all outputs 0 same cycle; after release, tx_en=1, fcws=0, nav=0 -> tx_src=+64 if first tx_chip=0, else -64.
REQ-035 Period: tx_prn_fcw=0x80000000, tx_en=1 -> tick every 2 cycles, tx_prn_sop spacing exactly 8184 cycles; tx_nav_req every 163680 cycles.
REQ-036 Code: first 2046 tx_chip values per period match golden Gold model for taps (1,3); identical across consecutive periods.
REQ-037 Stall: tx_en low 100 cycles mid-period -> tx_src_valid 0, tx_src frozen, resumed sequence identical to uninterrupted run shifted by 100 cycles.
REQ-038 Nav: tx_nav_bit=1 at tx_nav_req -> all tx_src after boundary negated versus nav=0 run.
REQ-039 Sync: tx_sync at chip 1000 -> tx_prn_sop next cycle, following sop 8184 cycles later, car phase continuous.

Source files
------------

// File: rtl/b1_boc_gen.sv
// B1-style BOC(1,1) signal generator: Gold-code chips, half-chip subcarrier and nav data
// modulate an 8-level carrier LUT driven by a 32-bit NCO.
module b1_boc_gen #(
    parameter int unsigned G2_TAP_A   = 1,
    parameter int unsigned G2_TAP_B   = 3,
    parameter int unsigned NAV_EPOCHS = 20
) (
    input  logic              rx_clk,
    input  logic              rx_rst,
    input  logic              tx_en,
    input  logic              tx_sync,
    input  logic [31:0]       tx_car_fcw,
    input  logic [31:0]       tx_prn_fcw,
    input  logic              tx_nav_bit,
    output logic signed [7:0] tx_src,
    output logic              tx_src_valid,
    output logic              tx_prn_sop,
    output logic              tx_nav_req,
    output logic              tx_chip
);

    localparam int unsigned EpochW = (NAV_EPOCHS > 1) ? $clog2(NAV_EPOCHS) : 1;
    localparam logic [EpochW-1:0] EpochLast = EpochW'(NAV_EPOCHS - 1);
    // Bit n-1 holds stage n; stage 1 first reads 01010101010.
    localparam logic [10:0] LfsrInit = 11'b010_1010_1010;
    localparam logic [10:0] ChipLast = 11'd2045;

    logic [31:0]       car_acc_q, car_acc_d;
    logic [31:0]       code_acc_q, code_acc_d;
    logic              sub_q, sub_d;
    logic [10:0]       g1_q, g1_d;
    logic [10:0]       g2_q, g2_d;
    logic [10:0]       chip_cnt_q, chip_cnt_d;
    logic [EpochW-1:0] epoch_cnt_q, epoch_cnt_d;
    logic              nav_q, nav_d;
    logic signed [7:0] tx_src_q, tx_src_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              nav_req_q, nav_req_d;

    logic [32:0]       code_sum;
    logic              g1_fb, g2_fb, chip, sign_d;
    logic signed [7:0] lut_val;

    assign chip     = g1_q[10] ^ g2_q[G2_TAP_A-1] ^ g2_q[G2_TAP_B-1];
    assign g1_fb    = g1_q[0] ^ g1_q[6] ^ g1_q[7] ^ g1_q[8] ^ g1_q[9] ^ g1_q[10];
    assign g2_fb    = g2_q[0] ^ g2_q[1] ^ g2_q[2] ^ g2_q[3] ^ g2_q[4] ^ g2_q[7] ^ g2_q[8]
                    ^ g2_q[10];
    assign code_sum = {1'b0, code_acc_q} + {1'b0, tx_prn_fcw};
    assign sign_d   = chip ^ sub_q ^ nav_q;

    always_comb begin
        unique case (car_acc_q[31:29])
            3'd0:    lut_val = 8'sd64;
            3'd1:    lut_val = 8'sd45;
            3'd2:    lut_val = 8'sd0;
            3'd3:    lut_val = -8'sd45;
            3'd4:    lut_val = -8'sd64;
            3'd5:    lut_val = -8'sd45;
            3'd6:    lut_val = 8'sd0;
            3'd7:    lut_val = 8'sd45;
            default: lut_val = 8'sd0;
        endcase
    end

    always_comb begin
        car_acc_d   = car_acc_q;
        code_acc_d  = code_acc_q;
        sub_d       = sub_q;
        g1_d        = g1_q;
        g2_d        = g2_q;
        chip_cnt_d  = chip_cnt_q;
        epoch_cnt_d = epoch_cnt_q;
        nav_d       = nav_q;
        tx_src_d    = tx_src_q;
        valid_d     = tx_en;
        sop_d       = 1'b0;
        nav_req_d   = 1'b0;

        if (tx_en) begin
            car_acc_d  = car_acc_q + tx_car_fcw;
            code_acc_d = code_sum[31:0];
            tx_src_d   = sign_d ? (8'sd0 - lut_val) : lut_val;
            if (code_sum[32]) begin
                sub_d = ~sub_q;
                // Second half-chip closes the chip.
                if (sub_q) begin
                    if (chip_cnt_q == ChipLast) begin
                        chip_cnt_d = '0;
                        g1_d       = LfsrInit;
                        g2_d       = LfsrInit;
                        sop_d      = 1'b1;
                        if (epoch_cnt_q == EpochLast) begin
                            epoch_cnt_d = '0;
                            nav_d       = tx_nav_bit;
                            nav_req_d   = 1'b1;
                        end else begin
                            epoch_cnt_d = epoch_cnt_q + 1'b1;
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + 11'd1;
                        g1_d       = {g1_q[9:0], g1_fb};
                        g2_d       = {g2_q[9:0], g2_fb};
                    end
                end
            end
        end

        // Restart overrides any wrap in the same cycle; carrier and nav keep running.
        if (tx_sync) begin
            code_acc_d  = '0;
            sub_d       = 1'b0;
            chip_cnt_d  = '0;
            epoch_cnt_d = '0;
            g1_d        = LfsrInit;
            g2_d        = LfsrInit;
            nav_d       = nav_q;
            sop_d       = 1'b1;
            nav_req_d   = 1'b0;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            car_acc_q   <= '0;
            code_acc_q  <= '0;
            sub_q       <= 1'b0;
            g1_q        <= LfsrInit;
            g2_q        <= LfsrInit;
            chip_cnt_q  <= '0;
            epoch_cnt_q <= '0;
            nav_q       <= 1'b0;
            tx_src_q    <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            nav_req_q   <= 1'b0;
        end else begin
            car_acc_q   <= car_acc_d;
            code_acc_q  <= code_acc_d;
            sub_q       <= sub_d;
            g1_q        <= g1_d;
            g2_q        <= g2_d;
            chip_cnt_q  <= chip_cnt_d;
            epoch_cnt_q <= epoch_cnt_d;
            nav_q       <= nav_d;
            tx_src_q    <= tx_src_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            nav_req_q   <= nav_req_d;
        end
    end

    assign tx_src       = tx_src_q;
    assign tx_src_valid = valid_q;
    assign tx_prn_sop   = sop_q;
    assign tx_nav_req   = nav_req_q;
    assign tx_chip      = chip;

endmodule
